// File: rtl/pseudo_spi_in_intf.sv
// Scan-chain read-back interface: strobes SEL to load the analog scan chain, then
// shifts it out with two-phase SCLK1/SCLK2 and writes each packed word to SRAM.
module pseudo_spi_in_intf #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8,
  parameter int PHASE_CYCLES      = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         SEL,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         CEN,
  output logic                         WEN,
  output logic                         spi_busy,
  output logic                         spi_is_done
);

  localparam int W  = MEMORY_DATA_WIDTH;
  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int LW = RESERVED_DATA_LEN;
  localparam int PW = $clog2(PHASE_CYCLES + 1);
  localparam int BW = $clog2(W + 1);

  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [BW-1:0] BITS_FULL  = BW'(W);
  localparam logic [LW-1:0] LAST_WORD  = LW'(1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    SAMP  = 4'd2,
    CLK1  = 4'd3,
    GAP1  = 4'd4,
    CLK2  = 4'd5,
    GAP2  = 4'd6,
    WRITE = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   phase_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [W-1:0]    shreg;
  logic [AW-1:0]   addr;
  logic [LW-1:0]   words_left;
  logic            timed_state;
  logic            phase_done;

  // LOAD, CLK1 and CLK2 each hold their strobe for PHASE_CYCLES cycles.
  assign timed_state = (state == LOAD) || (state == CLK1) || (state == CLK2);
  assign phase_done  = (phase_cnt == PHASE_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // START is a one-cycle request: honoured only in IDLE or DONE, ignored otherwise.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (START) begin
          state_next = (DATA_LEN != '0) ? LOAD : DONE;
        end
      end
      LOAD:  if (phase_done) state_next = SAMP;
      SAMP:  state_next = CLK1;
      CLK1:  if (phase_done) state_next = GAP1;
      GAP1:  state_next = CLK2;
      CLK2:  if (phase_done) state_next = GAP2;
      GAP2:  state_next = (bit_cnt == BITS_FULL) ? WRITE : SAMP;
      WRITE: state_next = (words_left == LAST_WORD) ? DONE : SAMP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_cnt <= '0;
    end else if (timed_state && !phase_done) begin
      phase_cnt <= phase_cnt + PW'(1);
    end else begin
      phase_cnt <= '0;
    end
  end

  // Bits arrive LSB first: each new bit enters at the top and walks down to bit 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      addr       <= '0;
      words_left <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (START) begin
            addr       <= ADDR_BGN;
            words_left <= DATA_LEN;
            bit_cnt    <= '0;
          end
        end
        SAMP: begin
          shreg   <= {SPI_SI, shreg[W-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
        end
        WRITE: begin
          addr       <= addr + AW'(1);
          words_left <= words_left - LW'(1);
          bit_cnt    <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign A  = addr;
  assign PO = shreg;

  always_comb begin
    SCLK1       = 1'b0;
    SCLK2       = 1'b0;
    SEL         = 1'b0;
    CEN         = 1'b1;
    WEN         = 1'b1;
    spi_busy    = 1'b1;
    spi_is_done = 1'b0;
    case (state)
      IDLE:  spi_busy = 1'b0;
      DONE: begin
        spi_busy    = 1'b0;
        spi_is_done = 1'b1;
      end
      LOAD:  SEL   = 1'b1;
      CLK1:  SCLK1 = 1'b1;
      CLK2:  SCLK2 = 1'b1;
      WRITE: begin
        CEN = 1'b0;
        WEN = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pseudo_spi_in_intf.sv
// Directed bench for pseudo_spi_in_intf: models the scan chain behind SPI_SI and
// scoreboards every SRAM write, pulse count and transfer latency.
module tb_pseudo_spi_in_intf;

  localparam int W  = 8;
  localparam int AW = 9;
  localparam int LW = 8;
  localparam int P  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] addr_bgn = '0;
  logic [LW-1:0] data_len = '0;
  logic          spi_si;
  logic          sclk1, sclk2, sel, cen, wen, spi_busy, spi_is_done;
  logic [AW-1:0] a;
  logic [W-1:0]  po;

  pseudo_spi_in_intf #(
    .MEMORY_DATA_WIDTH(W),
    .MEMORY_ADDR_WIDTH(AW),
    .RESERVED_DATA_LEN(LW),
    .PHASE_CYCLES(P)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .START(start),
    .ADDR_BGN(addr_bgn),
    .DATA_LEN(data_len),
    .SPI_SI(spi_si),
    .SCLK1(sclk1),
    .SCLK2(sclk2),
    .SEL(sel),
    .A(a),
    .PO(po),
    .CEN(cen),
    .WEN(wen),
    .spi_busy(spi_busy),
    .spi_is_done(spi_is_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scan-chain model: bit 0 after SEL, advances on each falling SCLK2
  logic [63:0] chain_bits = '0;
  int          bit_idx = 0;
  assign spi_si = (bit_idx < 64) ? chain_bits[bit_idx] : 1'b0;

  int   sel_cycles, sclk1_pulses, sclk2_pulses, overlap_cycles, write_cycles;
  logic sclk1_q = 1'b0;
  logic sclk2_q = 1'b0;

  always @(negedge clk) begin
    logic [AW+W-1:0] e;
    if (sel) begin
      sel_cycles++;
      bit_idx = 0;
    end
    if (sclk1 && !sclk1_q) sclk1_pulses++;
    if (sclk2 && !sclk2_q) sclk2_pulses++;
    if (!sclk2 && sclk2_q) bit_idx++;
    if (sclk1 && sclk2) overlap_cycles++;
    if (!cen || !wen) begin
      write_cycles++;
      check("cen_wen_together", {30'd0, cen, wen}, 32'd0);
      check("write_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", a, e[AW+W-1:W]);
        check("write_data", po, e[W-1:0]);
      end
    end
    sclk1_q = sclk1;
    sclk2_q = sclk2;
  end

  // driver tasks
  task automatic clear_counts();
    sel_cycles     = 0;
    sclk1_pulses   = 0;
    sclk2_pulses   = 0;
    overlap_cycles = 0;
    write_cycles   = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sclk1"}, sclk1, 0);
    check({tag, "_sclk2"}, sclk2, 0);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_cen"}, cen, 1);
    check({tag, "_wen"}, wen, 1);
    check({tag, "_busy"}, spi_busy, 0);
    check({tag, "_done"}, spi_is_done, 0);
  endtask

  task automatic run(input string tag, input logic [AW-1:0] ab, input int len,
                     input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                     input int exp_cycles, input int poke_at);
    int            cycles;
    logic [AW-1:0] ea;
    logic [7:0]    ws[3];
    ws[0] = w0;
    ws[1] = w1;
    ws[2] = w2;
    chain_bits = {40'h0, w2, w1, w0};
    ea = ab;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({ea, ws[i]});
      ea = ea + 1'b1;
    end
    @(posedge clk);
    #1;
    clear_counts();
    start    = 1'b1;
    addr_bgn = ab;
    data_len = LW'(len);
    cycles   = 0;
    do begin
      @(posedge clk);
      cycles++;
      #1;
      if (cycles == 1) begin
        start    = 1'b0;
        addr_bgn = AW'($urandom_range(0, 511));
        data_len = LW'($urandom_range(0, 255));
        if (len != 0) begin
          check({tag, "_busy_after_start"}, spi_busy, 1);
          check({tag, "_done_low_after_start"}, spi_is_done, 0);
        end
      end
      if (cycles == poke_at) begin
        start    = 1'b1;
        addr_bgn = 9'h100;
        data_len = 8'd5;
      end
      if (cycles == poke_at + 1) start = 1'b0;
    end while (!spi_is_done && cycles < 400);
    check({tag, "_latency"}, cycles, exp_cycles);
    check({tag, "_sel_cycles"}, sel_cycles, (len != 0) ? P : 0);
    check({tag, "_sclk1_pulses"}, sclk1_pulses, 8 * len);
    check({tag, "_sclk2_pulses"}, sclk2_pulses, 8 * len);
    check({tag, "_overlap"}, overlap_cycles, 0);
    check({tag, "_write_cycles"}, write_cycles, len);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_addr_after"}, a, ea);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_held"}, spi_is_done, 1);
    check({tag, "_busy_in_done"}, spi_busy, 0);
    check({tag, "_cen_in_done"}, cen, 1);
    exp_q.delete();
  endtask

  // stimulus
  initial begin
    int guard;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_a", a, 0);
    check("reset_po", po, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("idle_no_start");

    // abort a transfer while SCLK2 is high; nothing may be written
    chain_bits = {56'h0, 8'hA5};
    clear_counts();
    start    = 1'b1;
    addr_bgn = 9'h010;
    data_len = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!sclk2 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("abort_sclk2_seen", sclk2, 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_a", a, 0);
    check("async_reset_po", po, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_idle_outputs("after_reset");
    check("abort_no_write", write_cycles, 0);

    run("single", 9'h010, 1, 8'hA5, 8'h00, 8'h00, 94, -10);
    run("multi", 9'h020, 3, 8'h3C, 8'hFF, 8'h01, 272, -10);
    run("wrap", 9'h1FF, 2, 8'h5A, 8'hC3, 8'h00, 183, 60);
    run("zero", 9'h0AA, 0, 8'h00, 8'h00, 8'h00, 1, -10);
    run("restart", 9'h050, 1, 8'h96, 8'h00, 8'h00, 94, -10);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
